montgomery_modexp_core: RTL

Parametrised successor of montgomery_exp. Computes x^e mod m for odd m with no host-supplied R or bit length. It derives R^2 mod m internally and finds the exponent MSB itself. It adds a sticky-result start/done handshake and an error flag, and sits under the RSA top as the single modular exponentiation engine.

---
 rtl/rsa_pkg.sv | 24 ++
 rtl/montgomery_mul_serial.sv | 90 +++++++++
 rtl/montgomery_modexp_core.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types for the RSA datapath: default widths, operand typedefs and the
// modular-exponentiation FSM state encoding.
package rsa_pkg;

   localparam int unsigned DEFAULT_WORD_WIDTH = 32;
   localparam int unsigned DEFAULT_E_WIDTH    = 17;

   typedef logic [DEFAULT_WORD_WIDTH-1:0] word_t;
   typedef logic [DEFAULT_WORD_WIDTH+1:0] word_ext_t;

   typedef enum logic [3:0] {
      StIdle,
      StCheck,
      StR2,
      StXbar,
      StOne,
      StScan,
      StSqr,
      StMul,
      StConv,
      StDone
   } state_e;

endpackage

// File: rtl/montgomery_mul_serial.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*R^-1 mod m, R = 2^WORD_WIDTH.
// done pulses for one cycle WORD_WIDTH+2 cycles after start; result holds until the next start.
module montgomery_mul_serial
   import rsa_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] a,
   input  logic [WORD_WIDTH-1:0] b,
   input  logic [WORD_WIDTH-1:0] m,
   output logic                  done,
   output logic [WORD_WIDTH-1:0] result
);

   localparam int unsigned CntW = $clog2(WORD_WIDTH + 1);

   logic [WORD_WIDTH-1:0] a_q, a_d;
   logic [WORD_WIDTH-1:0] b_q, b_d;
   logic [WORD_WIDTH-1:0] m_q, m_d;
   logic [WORD_WIDTH-1:0] result_q, result_d;
   logic [WORD_WIDTH+1:0] u_q, u_d;
   logic [WORD_WIDTH+1:0] u_add, u_odd, m_ext;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  run_q, run_d;
   logic                  done_q, done_d;

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      m_d      = m_q;
      u_d      = u_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      result_d = result_q;
      done_d   = 1'b0;

      m_ext = {2'b00, m_q};
      u_add = u_q + (a_q[0] ? {2'b00, b_q} : '0);
      u_odd = u_add + (u_add[0] ? m_ext : '0);

      if (start) begin
         a_d   = a;
         b_d   = b;
         m_d   = m;
         u_d   = '0;
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         if (cnt_q == CntW'(WORD_WIDTH)) begin
            // u < 2m here, so a single subtract fully reduces it.
            result_d = WORD_WIDTH'((u_q >= m_ext) ? (u_q - m_ext) : u_q);
            run_d    = 1'b0;
            done_d   = 1'b1;
         end else begin
            u_d   = u_odd >> 1;
            a_d   = a_q >> 1;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= '0;
         u_q      <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         m_q      <= m_d;
         u_q      <= u_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign done   = done_q;
   assign result = result_q;

endmodule

// File: rtl/montgomery_modexp_core.sv
// Left-to-right Montgomery modular exponentiation x^e mod m for odd m. R^2 mod m and the
// exponent MSB are derived internally; one shared serial multiplier performs every MonPro.
module montgomery_modexp_core
   import rsa_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH,
   parameter int unsigned E_WIDTH    = DEFAULT_E_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [WORD_WIDTH-1:0] m,
   input  logic [WORD_WIDTH-1:0] x,
   input  logic [E_WIDTH-1:0]    e,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [WORD_WIDTH-1:0] exp_result
);

   localparam int unsigned IdxW   = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
   localparam int unsigned R2CntW = $clog2(2 * WORD_WIDTH);
   localparam logic [WORD_WIDTH-1:0] WordOne = WORD_WIDTH'(1);

   state_e state_q, state_d;

   logic [WORD_WIDTH-1:0] m_q, m_d;
   logic [WORD_WIDTH-1:0] x_q, x_d;
   logic [E_WIDTH-1:0]    e_q, e_d;
   logic [WORD_WIDTH:0]   r_q, r_d;
   logic [R2CntW-1:0]     r2cnt_q, r2cnt_d;
   logic [WORD_WIDTH-1:0] xbar_q, xbar_d;
   logic [WORD_WIDTH-1:0] acc_q, acc_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic [WORD_WIDTH-1:0] result_q, result_d;

   logic [WORD_WIDTH:0]   r_dbl, r_step;
   logic                  step_next;
   logic                  mul_start, mul_done;
   logic [WORD_WIDTH-1:0] mul_a, mul_b, mul_result;

   montgomery_mul_serial #(
      .WORD_WIDTH(WORD_WIDTH)
   ) u_mul (
      .clk   (clk),
      .reset (reset),
      .start (mul_start),
      .a     (mul_a),
      .b     (mul_b),
      .m     (m_q),
      .done  (mul_done),
      .result(mul_result)
   );

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      x_d       = x_q;
      e_d       = e_q;
      r_d       = r_q;
      r2cnt_d   = r2cnt_q;
      xbar_d    = xbar_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      busy_d    = busy_q;
      done_d    = done_q;
      error_d   = error_q;
      result_d  = result_q;
      step_next = 1'b0;
      mul_start = 1'b0;
      mul_a     = acc_q;
      mul_b     = acc_q;

      r_dbl  = r_q << 1;
      r_step = (r_dbl >= {1'b0, m_q}) ? (r_dbl - {1'b0, m_q}) : r_dbl;

      // Each MonPro is launched in the cycle that enters its state, with operands taken
      // from the value being written back so that chained products need no extra cycle.
      unique case (state_q)
         StIdle, StDone: begin
            if (state_q == StDone && !done_q) begin
               done_d = 1'b1;
               busy_d = 1'b0;
            end
            if (enable && !busy_q) begin
               m_d     = m;
               x_d     = x;
               e_d     = e;
               done_d  = 1'b0;
               error_d = 1'b0;
               busy_d  = 1'b1;
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (!m_q[0] || (x_q >= m_q)) begin
               error_d  = 1'b1;
               result_d = '0;
               state_d  = StDone;
            end else begin
               r_d     = (WORD_WIDTH + 1)'(1);
               r2cnt_d = '0;
               idx_d   = IdxW'(E_WIDTH - 1);
               state_d = StR2;
            end
         end
         StR2: begin
            r_d     = r_step;
            r2cnt_d = r2cnt_q + 1'b1;
            if (r2cnt_q == R2CntW'(2 * WORD_WIDTH - 1)) begin
               state_d   = StXbar;
               mul_start = 1'b1;
               mul_a     = x_q;
               mul_b     = r_step[WORD_WIDTH-1:0];
            end
         end
         StXbar: begin
            if (mul_done) begin
               xbar_d    = mul_result;
               state_d   = StOne;
               mul_start = 1'b1;
               mul_a     = r_q[WORD_WIDTH-1:0];
               mul_b     = WordOne;
            end
         end
         StOne: begin
            if (mul_done) begin
               acc_d   = mul_result;
               state_d = StScan;
            end
         end
         StScan: begin
            if (e_q[idx_q]) begin
               state_d   = StSqr;
               mul_start = 1'b1;
            end else if (idx_q == '0) begin
               state_d   = StConv;
               mul_start = 1'b1;
               mul_b     = WordOne;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         StSqr: begin
            if (mul_done) begin
               acc_d = mul_result;
               if (e_q[idx_q]) begin
                  state_d   = StMul;
                  mul_start = 1'b1;
                  mul_a     = mul_result;
                  mul_b     = xbar_q;
               end else begin
                  step_next = 1'b1;
               end
            end
         end
         StMul: begin
            if (mul_done) begin
               acc_d     = mul_result;
               step_next = 1'b1;
            end
         end
         StConv: begin
            if (mul_done) begin
               result_d = mul_result;
               state_d  = StDone;
            end
         end
         default: state_d = StIdle;
      endcase

      // Zero-cycle advance to the next exponent bit, sharing the multiplier's done edge.
      if (step_next) begin
         mul_start = 1'b1;
         mul_a     = mul_result;
         if (idx_q == '0) begin
            state_d = StConv;
            mul_b   = WordOne;
         end else begin
            idx_d   = idx_q - 1'b1;
            state_d = StSqr;
            mul_b   = mul_result;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         m_q      <= '0;
         x_q      <= '0;
         e_q      <= '0;
         r_q      <= '0;
         r2cnt_q  <= '0;
         xbar_q   <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         x_q      <= x_d;
         e_q      <= e_d;
         r_q      <= r_d;
         r2cnt_q  <= r2cnt_d;
         xbar_q   <= xbar_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
         result_q <= result_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign exp_result = result_q;

endmodule
